// File: rtl/mux_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter_pkg
// Shared definitions for the round-robin mux arbiter:
//   - N_REQ       : number of requesters sharing the mux path
//   - state_t     : arbiter FSM states (ST_IDLE = 1'b0, ST_GRANT = 1'b1)
//   - pick_t      : result of a round-robin search (valid flag + index)
//   - rr_pick     : rotating-priority search starting after the last owner
//   - idx_to_onehot : requester index to one-hot grant vector
// -----------------------------------------------------------------------------
package mux_rr_arbiter_pkg;

   localparam int N_REQ = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } pick_t;

   // Searches last+1, last+2, last+3, last+4 (mod 4) and returns the first
   // requester found. The 2-bit candidate wraps naturally, so last+4 is the
   // last owner itself and it only wins when nobody else is asking.
   function automatic pick_t rr_pick(input logic [3:0] req, input logic [1:0] last);
      pick_t      res;
      logic [1:0] cand;
      logic       found;
      res.valid = 1'b0;
      res.idx   = 2'd0;
      for (int i = 1; i <= N_REQ; i++) begin
         cand      = last + 2'(i);
         found     = req[cand] & ~res.valid;
         res.idx   = found ? cand : res.idx;
         res.valid = res.valid | req[cand];
      end
      return res;
   endfunction

   function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux_4_1.sv
// -----------------------------------------------------------------------------
// mux_4_1
// Combinational 4:1 single-bit multiplexer.
// Ports:
//   S1, S0        : select, {S1,S0} = index of the input passed to Y
//   I3, I2, I1, I0: data inputs
//   Y             : selected data bit
// -----------------------------------------------------------------------------
module mux_4_1 (
   input  logic S1,
   input  logic S0,
   input  logic I3,
   input  logic I2,
   input  logic I1,
   input  logic I0,
   output logic Y
);

   // Select one of the four data bits
   always_comb begin
      Y = 1'b0;
      case ({S1, S0})
         2'b00:   Y = I0;
         2'b01:   Y = I1;
         2'b10:   Y = I2;
         2'b11:   Y = I3;
         default: Y = 1'b0;
      endcase
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
// Round-robin arbiter sharing one 4:1 single-bit mux path among four
// requesters. An owner keeps the path while it requests; when others are
// waiting it is limited to MAX_HOLD consecutive cycles, after which ownership
// rotates to the next waiting requester.
// Parameters:
//   MAX_HOLD : max consecutive grant cycles under contention (2..255)
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   req[3:0]       : request lines
//   I3, I2, I1, I0 : data bits from requesters 3..0
//   gnt[3:0]       : registered one-hot grant, zero when idle
//   S1, S0         : registered mux select (current or last owner)
//   busy           : registered, high while a grant is active
//   Y              : selected data bit gated by busy (combinational)
// -----------------------------------------------------------------------------
module mux_rr_arbiter
   import mux_rr_arbiter_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       I3,
   input  logic       I2,
   input  logic       I1,
   input  logic       I0,
   output logic [3:0] gnt,
   output logic       S1,
   output logic       S0,
   output logic       busy,
   output logic       Y
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   state_t           state_r;
   logic [1:0]       last_r;
   logic [CNT_W-1:0] hold_cnt_r;

   pick_t            idle_pick_s;
   pick_t            other_pick_s;
   logic             owner_req_s;
   logic             hold_done_s;
   logic             mux_y_s;

   // From idle every requester competes, starting after the last owner.
   assign idle_pick_s  = rr_pick(req, last_r);
   // While granted, only the other requesters count as contenders.
   assign other_pick_s = rr_pick(req & ~idx_to_onehot(last_r), last_r);
   assign owner_req_s  = req[last_r];
   // The counter saturates at HOLD_LAST, so equality also covers "at or past".
   assign hold_done_s  = (hold_cnt_r == HOLD_LAST);

   // Arbiter FSM: ownership, hold counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         last_r     <= 2'd3;
         hold_cnt_r <= {CNT_W{1'b0}};
         gnt        <= 4'b0000;
         S1         <= 1'b0;
         S0         <= 1'b0;
         busy       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (idle_pick_s.valid) begin
                  state_r    <= ST_GRANT;
                  last_r     <= idle_pick_s.idx;
                  hold_cnt_r <= {CNT_W{1'b0}};
                  gnt        <= idx_to_onehot(idle_pick_s.idx);
                  {S1, S0}   <= idle_pick_s.idx;
                  busy       <= 1'b1;
               end else begin
                  state_r    <= ST_IDLE;
               end
            end
            ST_GRANT: begin
               if (owner_req_s && !other_pick_s.valid) begin
                  // Sole requester: keep the grant, count up to the limit only.
                  hold_cnt_r <= hold_done_s ? hold_cnt_r : hold_cnt_r + CNT_W'(1);
               end else if (owner_req_s && !hold_done_s) begin
                  hold_cnt_r <= hold_cnt_r + CNT_W'(1);
               end else if (other_pick_s.valid) begin
                  // Forced rotation at the limit, or direct handover on release.
                  last_r     <= other_pick_s.idx;
                  hold_cnt_r <= {CNT_W{1'b0}};
                  gnt        <= idx_to_onehot(other_pick_s.idx);
                  {S1, S0}   <= other_pick_s.idx;
                  busy       <= 1'b1;
               end else begin
                  // Released with nobody waiting; select keeps the old owner.
                  state_r    <= ST_IDLE;
                  hold_cnt_r <= {CNT_W{1'b0}};
                  gnt        <= 4'b0000;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               hold_cnt_r <= {CNT_W{1'b0}};
               gnt        <= 4'b0000;
               busy       <= 1'b0;
            end
         endcase
      end
   end

   mux_4_1 u_mux (
      .S1 (S1),
      .S0 (S0),
      .I3 (I3),
      .I2 (I2),
      .I1 (I1),
      .I0 (I0),
      .Y  (mux_y_s)
   );

   assign Y = mux_y_s & busy;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
// Self-checking bench for mux_rr_arbiter: directed scenarios followed by a
// randomized phase, every cycle compared against an integer-level model of
// the ownership rules.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

   localparam int MAX_HOLD = 8;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       I3, I2, I1, I0;
   logic [3:0] gnt;
   logic       S1, S0, busy, Y;

   int tests = 0;
   int fails = 0;

   // Reference model state: owner index (-1 when idle), priority pointer,
   // cycles the owner has held the grant, and the select value.
   int         m_owner;
   int         m_last;
   int         m_held;
   logic [1:0] m_sel;

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .I3   (I3),
      .I2   (I2),
      .I1   (I1),
      .I0   (I0),
      .gnt  (gnt),
      .S1   (S1),
      .S0   (S0),
      .busy (busy),
      .Y    (Y)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // First requester after 'from' in rotating order, skipping 'excl'; -1 if none.
   function automatic int pick(input logic [3:0] r, input int from, input int excl);
      for (int i = 1; i <= 4; i++) begin
         int k;
         k = (from + i) % 4;
         if (r[k] && k != excl) return k;
      end
      return -1;
   endfunction

   // Apply inputs for one cycle, advance the model, check after the edge.
   task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic rs);
      int         w;
      logic [3:0] eg;
      logic       eb;
      req = r;
      {I3, I2, I1, I0} = d;
      rst = rs;
      if (rs) begin
         m_owner = -1; m_last = 3; m_held = 0; m_sel = 2'd0;
      end else if (m_owner < 0) begin
         w = pick(r, m_last, -1);
         if (w >= 0) begin
            m_owner = w; m_last = w; m_sel = 2'(w); m_held = 1;
         end
      end else begin
         w = pick(r, m_owner, m_owner);
         if (r[m_owner] && (w < 0 || m_held < MAX_HOLD)) begin
            if (m_held < MAX_HOLD) m_held++;
         end else if (w >= 0) begin
            m_owner = w; m_last = w; m_sel = 2'(w); m_held = 1;
         end else begin
            m_owner = -1; m_held = 0;
         end
      end
      @(posedge clk);
      #1;
      eb = (m_owner >= 0);
      eg = eb ? (4'b0001 << m_owner) : 4'b0000;
      chk("model_gnt",  {4'b0000, gnt},  {4'b0000, eg});
      chk("model_sel",  {6'b0, S1, S0},  {6'b0, m_sel});
      chk("model_busy", {7'b0, busy},    {7'b0, eb});
      chk("model_y",    {7'b0, Y},       {7'b0, d[m_sel] & eb});
      @(negedge clk);
   endtask

   initial begin
      logic [3:0] r;
      clk = 1'b0;
      rst = 1'b1;
      req = 4'b0000;
      {I3, I2, I1, I0} = 4'b0000;
      m_owner = -1; m_last = 3; m_held = 0; m_sel = 2'd0;

      // Reset held two cycles while everyone requests
      cycle(4'b1111, 4'b1111, 1'b1);
      cycle(4'b1111, 4'b1111, 1'b1);
      chk("rst_gnt",  {4'b0, gnt},    8'h00);
      chk("rst_busy", {7'b0, busy},   8'h00);
      chk("rst_sel",  {6'b0, S1, S0}, 8'h00);
      chk("rst_y",    {7'b0, Y},      8'h00);
      cycle(4'b1111, 4'b1111, 1'b0);
      chk("post_rst_gnt", {4'b0, gnt},    8'h01);
      chk("post_rst_sel", {6'b0, S1, S0}, 8'h00);

      // Single requester 2, data toggling, held 20 cycles
      cycle(4'b0000, 4'b0000, 1'b0);
      for (int c = 0; c < 20; c++) begin
         logic tog;
         tog = ~c[0];
         cycle(4'b0100, {1'b0, tog, 2'b00}, 1'b0);
         chk("single_gnt", {4'b0, gnt},    8'h04);
         chk("single_sel", {6'b0, S1, S0}, 8'h02);
         chk("single_y",   {7'b0, Y},      {7'b0, tog});
      end
      cycle(4'b0000, 4'b1111, 1'b0);
      chk("single_drop_gnt",  {4'b0, gnt},    8'h00);
      chk("single_drop_busy", {7'b0, busy},   8'h00);
      chk("single_drop_sel",  {6'b0, S1, S0}, 8'h02);

      // Fairness: all four requesting, each holds MAX_HOLD cycles in order
      cycle(4'b1111, 4'b0000, 1'b1);
      for (int c = 0; c < 5 * MAX_HOLD; c++) begin
         logic [3:0] eg;
         eg = 4'b0001 << ((c / MAX_HOLD) % 4);
         cycle(4'b1111, 4'($urandom), 1'b0);
         chk("rr_gnt", {4'b0, gnt}, {4'b0, eg});
      end

      // Direct handover from owner 1 to owner 3
      cycle(4'b0000, 4'b0000, 1'b1);
      cycle(4'b0010, 4'b0000, 1'b0);
      chk("ho_start_gnt", {4'b0, gnt}, 8'h02);
      for (int c = 0; c < 3; c++) cycle(4'b1010, 4'b1010, 1'b0);
      chk("ho_before_gnt", {4'b0, gnt}, 8'h02);
      cycle(4'b1000, 4'b1000, 1'b0);
      chk("ho_gnt",  {4'b0, gnt},    8'h08);
      chk("ho_sel",  {6'b0, S1, S0}, 8'h03);
      chk("ho_busy", {7'b0, busy},   8'h01);

      // Priority rotation after release
      cycle(4'b0011, 4'b0000, 1'b0);
      chk("prio_gnt0", {4'b0, gnt}, 8'h01);
      cycle(4'b0010, 4'b0000, 1'b0);
      chk("prio_gnt1", {4'b0, gnt}, 8'h02);

      // Reset in the middle of a grant with hold count at 5
      cycle(4'b0000, 4'b0000, 1'b0);
      for (int c = 0; c < 6; c++) cycle(4'b0100, 4'b0100, 1'b0);
      chk("mid_pre_gnt", {4'b0, gnt}, 8'h04);
      cycle(4'b0100, 4'b0100, 1'b1);
      chk("mid_rst_gnt",  {4'b0, gnt},  8'h00);
      chk("mid_rst_busy", {7'b0, busy}, 8'h00);
      cycle(4'b0100, 4'b0100, 1'b0);
      chk("mid_regrant_gnt", {4'b0, gnt}, 8'h04);

      // Randomized traffic with sticky requests and rare resets
      r = 4'b0000;
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 9) < 3) r = 4'($urandom_range(0, 15));
         cycle(r, 4'($urandom), ($urandom_range(0, 79) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 single-bit mux path among four requesters.
- Each requester raises its request line. The block grants one owner at a time and drives the mux select (S1,S0) for that owner. It also gates the mux output Y.
- Grant is held while the owner keeps requesting, up to a hold limit. At the limit, ownership rotates to the next waiting requester, which bounds latency for every requester.
- Sits between four bit-serial sources and one shared single-bit sink.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one owner keeps the grant while another request is pending. Legal range 2..255.
- CNT_W, 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request lines, req[k] = requester k wants the path
- I3,I2,I1,I0  input  1 each  data bit from requester 3..0
- gnt  output  4  one-hot grant, registered; all zero when idle
- S1,S0  output  1 each  registered mux select = index of current/last owner
- busy  output  1  registered, 1 while a grant is active
- Y  output  1  combinational: selected data bit when busy=1, else 0

Behaviour:
- Reset (rst=1 at clk edge, takes priority over all else):
  - gnt=0000, S1S0=00, busy=0, hold_cnt=0, state=IDLE.
  - last_owner=3, so requester 0 has first priority after reset.
  - rst asserted mid-grant drops the grant at that edge. No handover.
- States are IDLE and GRANT.
- IDLE:
  - req=0000 → stay in IDLE, outputs unchanged.
  - Any req bit set → choose the first set bit searching last_owner+1, +2, +3, +4 (mod 4).
  - Next edge: gnt=onehot(winner), S1S0=winner, busy=1, hold_cnt=0, last_owner=winner, state=GRANT.
  - Latency from req sampled high to gnt high is 1 cycle.
- GRANT (owner = last_owner):
  - req[owner]=1 and no other req → keep grant; hold_cnt saturates at MAX_HOLD-1. No rotation with no contender.
  - req[owner]=1, others pending, hold_cnt<MAX_HOLD-1 → keep grant, hold_cnt+1.
  - req[owner]=1, others pending, hold_cnt==MAX_HOLD-1 → forced rotation. Next edge grants the RR winner among the other requesters; hold_cnt=0.
  - req[owner]=0, others pending → direct handover on that same edge to the RR winner. No idle gap.
  - req[owner]=0, no others → next edge: gnt=0000, busy=0, state=IDLE.
  - S1S0 keeps the last owner's index so the mux select does not toggle.
- Simultaneous events:
  - Several requests in the same cycle are resolved purely by rotating priority.
  - A requester that is granted and deasserts in the same cycle still counts as a 1-cycle grant; the release is seen the following edge.
- Invariants:
  - gnt has at most one bit set.
  - busy == |gnt.
  - When busy=1, gnt[{S1,S0}]=1.
  - Y = I[{S1,S0}] & busy.
- Fairness: with all four requesting continuously, each owner holds exactly MAX_HOLD cycles, in order 0,1,2,3,0,...

Decomposition:
- Shared package:
  - state encoding localparams ST_IDLE=1'b0, ST_GRANT=1'b1
  - function rr_pick(req[3:0], last[1:0]) returning the index plus a valid bit
  - localparam N_REQ=4
- One sub-module, mux_4_1: the existing combinational 4:1 mux, instantiated with S1,S0 and I3..I0. Its output is ANDed with busy to form Y.
- The arbiter FSM and the hold counter stay in the top module.

Test Plan:
- Reset: apply rst=1 for 2 cycles with req=1111 → gnt=0000, busy=0, S1S0=00, Y=0. Release rst → next edge gnt=0001, S1S0=00.
- Single requester: req=0100, I2 toggling 1,0,1 → gnt=0100 after 1 cycle, S1S0=10, and Y follows I2. Hold req for 20 cycles → grant held all 20 with no rotation. Drop req → next edge gnt=0000, busy=0.
- Round robin: req=1111 held, MAX_HOLD=8 → gnt sequence 0001 (8 cycles), 0010 (8), 0100 (8), 1000 (8), then 0001 again.
- Direct handover: owner 1 active, req=1010, then req[1] drops → next edge gnt=1000, S1S0=11, busy stays 1 throughout.
- Priority rotation: owner 3 releases while req=0011 → gnt=0001. Requester 0 releases, req=0010 → gnt=0010.
- Reset mid-grant: gnt=0100, hold_cnt=5, rst pulsed 1 cycle with req=0100 → gnt=0000 at that edge. Regrant 0100 one cycle after rst drops.
